// File: rtl/audio_decimator.sv
// Power-of-two audio decimator: boxcar mean (or D-th sample pick) of D input samples,
// one-word output register. Optional DECIM_DROP_COUNT_EN adds a saturating dropped-result counter.
module audio_decimator #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int LOG2_DECIM = 6,
  parameter int FRAC_BITS  = 8,
  parameter int AVERAGE    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data
`ifdef DECIM_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int ACC_W = IN_W + LOG2_DECIM;
  localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG2_DECIM) - 1);

  if (OUT_W < IN_W + FRAC_BITS) begin : g_bad_out_w
    $error("audio_decimator: OUT_W must be >= IN_W + FRAC_BITS");
  end
  if (LOG2_DECIM < 0 || LOG2_DECIM > 10) begin : g_bad_decim
    $error("audio_decimator: LOG2_DECIM must be in 0..10");
  end

  // Handshakes: a word moves only on a rising edge where valid and ready are both 1.
  // The input side never stalls; in_ready only reports that reset has been released.
  logic                   r_ready;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_valid;
  logic [OUT_W-1:0]       r_data;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_new;
  logic signed [IN_W-1:0] w_result;
  logic signed [OUT_W-1:0] w_word;

  assign w_accept = in_valid && !flush;
  assign w_last   = (r_cnt == LAST_IDX);
  assign w_new    = w_accept && w_last;

  if (AVERAGE != 0) begin : g_avg
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;

    assign w_sum    = r_acc + ACC_W'(in_data);
    // Arithmetic shift gives floor toward minus infinity for the mean.
    assign w_result = IN_W'(w_sum >>> LOG2_DECIM);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (flush) begin
        r_acc <= '0;
      end else if (w_accept) begin
        r_acc <= w_last ? '0 : w_sum;
      end
    end
  end else begin : g_pick
    assign w_result = in_data;
  end

  assign w_word = OUT_W'(w_result) << FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ready <= 1'b1;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // A new result loads if the register is empty or emptying this edge; otherwise it is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_new && (!r_valid || out_ready)) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DECIM_DROP_COUNT_EN
  logic [15:0] r_drop;
  logic        w_drop;

  assign w_drop = w_new && r_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 16'hFFFF)) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign drop_count = r_drop;
`endif

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: doc/audio_decimator.md
AUDIO_DECIMATOR -- requirements
Module: audio_decimator

Interface
REQ-001 Parameter IN_W, default 16, signed input sample width.
REQ-002 Parameter OUT_W, default 32, output word width; SHALL satisfy OUT_W >= IN_W + FRAC_BITS (elaboration error otherwise).
REQ-003 Parameter LOG2_DECIM, default 6, decimation factor D = 2^LOG2_DECIM, range 0..10.
REQ-004 Parameter FRAC_BITS, default 8, zero LSBs appended to output.
REQ-005 Parameter AVERAGE, default 1; 1 = boxcar mean of D samples, 0 = keep D-th sample only.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 flush  input  1  synchronous group restart.
REQ-009 in_valid  input  1  input sample present.
REQ-010 in_data  input  IN_W  signed two's-complement sample.
REQ-011 in_ready  output  1  always 1 out of reset; the source has no backpressure.
REQ-012 out_valid  output  1  decimated word held.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_data  output  OUT_W  decimated word.
REQ-015 drop_count  output  16  present only under DECIM_DROP_COUNT_EN.

Function
REQ-016 A sample SHALL be accepted on every cycle with in_valid=1 and flush=0.
REQ-017 Group counter SHALL count accepted samples 0..D-1 and wrap to 0 on the D-th accept.
REQ-018 Accumulator SHALL be signed, IN_W+LOG2_DECIM bits, and SHALL never overflow.
REQ-019 AVERAGE=1: result = (sum of D samples) arithmetic-shifted right LOG2_DECIM (floor toward minus infinity).
REQ-020 AVERAGE=0: result = the D-th sample of the group; the accumulator SHALL be unused.
REQ-021 out_data SHALL be {sign-extension, IN_W-bit result, FRAC_BITS zeros}.
REQ-022 Latency: out_valid SHALL rise on the cycle after the D-th sample is accepted.
REQ-023 Output register holds one word; out_valid=1 and out_ready=1 SHALL complete the transfer on that edge.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 New result with out_valid=1 and out_ready=0: the new result SHALL be dropped and the held word kept.
REQ-026 New result in the same cycle as a completing transfer: the new word SHALL load and out_valid SHALL stay 1.
REQ-027 flush=1 SHALL zero the group counter and accumulator, discard any same-cycle input, and leave the output register untouched.
REQ-028 D=1 (LOG2_DECIM=0): every accepted sample SHALL produce a result.

Reset
REQ-029 rst_n low SHALL asynchronously clear the group counter, accumulator, out_valid, out_data, and drop_count.
REQ-030 in_ready SHALL be 0 while rst_n is low and 1 from the first clock edge after release.
REQ-031 Reset mid-group SHALL discard the partial group; the next result covers only post-reset samples.

Configuration
REQ-032 Macro DECIM_DROP_COUNT_EN defined: drop_count SHALL increment once per result dropped under REQ-025, saturating at 0xFFFF and cleared only by reset.
REQ-033 DECIM_DROP_COUNT_EN undefined: the drop_count port and its logic SHALL be absent; all other behaviour is identical.

Verification (LOG2_DECIM=2, IN_W=16, OUT_W=32, FRAC_BITS=8 unless noted)
REQ-034 AVERAGE=1, out_ready=1, inputs 4,8,-4,12 -> one out_valid pulse the cycle after 12, out_data=0x00000500.
REQ-035 AVERAGE=1, inputs -1,-1,-1,-1 -> 0xFFFFFF00. Inputs 1,0,0,0 -> 0x00000000 (floor).
REQ-036 AVERAGE=0, inputs 4,8,-4,12 -> 0x00000C00.
REQ-037 out_ready=0 across two full groups (means 5 then 7) -> out_data holds 0x00000500, drop_count=1. Then out_ready=1 -> one transfer of 0x00000500.
REQ-038 Two samples, then rst_n pulse low, then 2,2,2,2 -> out_data=0x00000200. Repeat using flush instead of reset -> same result, with a previously held output word retained.
REQ-039 Transfer completing in the same cycle a new result forms -> out_valid stays 1 and the new word appears. No drop and no count increment.
